bldc_six_step_ctrl: RTL and testbench
=====================================

Name: bldc_six_step_ctrl

Overview:
- 6-step (trapezoidal) commutation controller that sequences the three per-phase deadtime complementary drivers (A, B, C).
- Converts filtered Hall code, direction and a shared PWM carrier into per-phase enable and in_pwm.
- Handles the bootstrap precharge, brake, stall and fault state machine.
- Sits between the PS-side control registers/PWM generator and the three deadtime drivers. Dead-time insertion remains in the drivers.

Parameters:
- HALL_STABLE, 16, consecutive identical synchronized Hall samples required before a code is accepted (1..65535).
- PRECHARGE_CYCLES, 1000, low-side-on bootstrap precharge length in clk cycles (≥1).
- STALL_CYCLES, 24'd5_000_000, maximum clk cycles between accepted Hall changes in RUN before a stall fault (≥1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = request motor run
- dir  in  1  0 = forward sector table, 1 = reverse (high/low phase roles swapped)
- brake  in  1  level; 1 in RUN = all low sides on
- pwm_in  in  1  PWM carrier from the PWM generator, already synchronous to clk
- hall  in  3  raw Hall inputs {C,B,A}, asynchronous
- ext_fault  in  1  external gate-driver/overcurrent fault, asynchronous
- fault_clr  in  1  single-cycle pulse; clears the latched fault
- ph_en  out  3  per-phase driver enable {C,B,A}
- ph_pwm  out  3  per-phase driver in_pwm {C,B,A}
- sector  out  3  current sector 0..5; 7 = invalid/none
- comm_pulse  out  1  one-cycle pulse on each accepted sector change in RUN
- state  out  3  FSM state encoding
- fault  out  1  latched fault flag
- fault_code  out  2  0 none, 1 ext, 2 invalid Hall, 3 stall

Behaviour:
- Reset (asynchronous, active-high) sets:
  - ph_en=0, ph_pwm=0, sector=7, comm_pulse=0, state=IDLE, fault=0, fault_code=0.
  - Hall filter count=0 and accepted code=3'b000.
- Input synchronization: hall and ext_fault each pass through 2-flop synchronizers.
- Hall filter:
  - Compares each synchronized sample with the previous one; the counter resets on any difference.
  - The code is accepted when the counter reaches HALL_STABLE-1.
  - A raw change that is stable from cycle t is accepted at t+2+HALL_STABLE.
  - Outputs update the cycle after acceptance. Total latency is HALL_STABLE+3.
- Sector map (accepted code → sector): 101→0, 100→1, 110→2, 010→3, 011→4, 001→5. Codes 000 and 111 are invalid.
- Forward drive table (high phase / low phase, third phase floating):
  - s0: A/B, s1: A/C, s2: B/C, s3: B/A, s4: C/A, s5: C/B.
  - dir=1 uses the same table with high and low swapped.
- Per-phase outputs:
  - High phase: en=1, pwm=pwm_in registered (1-cycle delay).
  - Low phase: en=1, pwm=0.
  - Float phase: en=0, pwm=0.
- FSM states: IDLE=0, PRECHARGE=1, RUN=2, BRAKE=3, FAULT=4.
  - IDLE: all en=0. run=1 and fault=0 → PRECHARGE.
  - PRECHARGE: ph_en=3'b111, ph_pwm=3'b000 for exactly PRECHARGE_CYCLES cycles, then → RUN. run=0 → IDLE immediately.
  - RUN: drive table from the current sector.
    - brake=1 → BRAKE.
    - run=0 → IDLE.
  - BRAKE: ph_en=3'b111, ph_pwm=0.
    - brake=0 and run=1 → RUN.
    - run=0 → IDLE.
  - FAULT: all en=0. Exits to IDLE only when fault_clr=1 and run=0. fault_clr while run=1 is ignored.
- Fault sources (entered from any state; each sets fault=1 and the code):
  - Synchronized ext_fault=1 → code 1.
  - In RUN or BRAKE only, an accepted invalid Hall code → code 2.
  - In RUN only, stall counter reaching STALL_CYCLES → code 3.
- Fault priority and updates:
  - Priority when simultaneous: ext > invalid Hall > stall.
  - fault_code is not overwritten while fault=1.
  - A fault overrides run/brake in the same cycle. Outputs are zero the cycle after the fault is detected.
- Stall counter:
  - Clears on entry to RUN and on each accepted sector change.
  - Saturates; does not run in BRAKE.
- comm_pulse: asserted only in RUN, for the one cycle in which the registered sector changes.
- dir change during RUN: takes effect on the next output register update. No special sequencing is required; the drivers insert deadtime.
- fault_clr and ext_fault together: fault stays set.

Decomposition:
- Shared package bldc_pkg holds:
  - FSM state localparams.
  - Fault code localparams.
  - Hall-to-sector function.
  - Sector-to-{high,low} phase table function.
- One sub-module, hall_filter (synchronizer + stability counter + valid/invalid flag + change strobe), instantiated once.

Test Plan:
- Reset, run=1, hall=101, HALL_STABLE=4, PRECHARGE_CYCLES=10 → ph_en=111/ph_pwm=000 for 10 cycles. Then RUN with ph_en=011, ph_pwm[A]=pwm_in delayed 1, ph_pwm[B]=0.
- Forward Hall sequence 101,100,110,010,011,001 held 20 cycles each → sectors 0..5, one comm_pulse per step, floating phase en=0. Repeat with dir=1 → high and low phases swapped.
- Hall glitch 101→100 lasting 3 cycles with HALL_STABLE=4 → no sector change, no comm_pulse.
- In RUN, hall=111 held stable → fault=1, fault_code=2, state=FAULT, ph_en=000. fault_clr with run=1 → fault remains. Set run=0, then fault_clr → IDLE, fault=0.
- STALL_CYCLES=100, Hall frozen in RUN → fault_code=3 at the 100th cycle. With ext_fault and invalid Hall asserted in the same cycle → fault_code=1.
- brake=1 in RUN → ph_en=111, ph_pwm=000, state=BRAKE, no stall fault after 200 cycles. brake=0 → RUN resumes with the current sector.

Source files
------------

// File: rtl/bldc_pkg.sv
// Shared constants and table functions for the six-step commutation controller.
package bldc_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRECHARGE = 3'd1;
  localparam logic [2:0] ST_RUN       = 3'd2;
  localparam logic [2:0] ST_BRAKE     = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;

  localparam logic [1:0] FC_NONE  = 2'd0;
  localparam logic [1:0] FC_EXT   = 2'd1;
  localparam logic [1:0] FC_HALL  = 2'd2;
  localparam logic [1:0] FC_STALL = 2'd3;

  localparam logic [2:0] SECTOR_NONE = 3'd7;

  // One-hot {C,B,A} masks of the phase switched high and the phase held low.
  typedef struct packed {
    logic [2:0] hi;
    logic [2:0] lo;
  } phase_sel_t;

  // Hall code {C,B,A} to sector; 000/111 are not legal Hall states.
  function automatic logic [2:0] hall_to_sector(input logic [2:0] code);
    logic [2:0] sec;
    case (code)
      3'b101:  sec = 3'd0;
      3'b100:  sec = 3'd1;
      3'b110:  sec = 3'd2;
      3'b010:  sec = 3'd3;
      3'b011:  sec = 3'd4;
      3'b001:  sec = 3'd5;
      default: sec = SECTOR_NONE;
    endcase
    return sec;
  endfunction

  // Forward drive table; reverse rotation swaps the high and low roles.
  function automatic phase_sel_t sector_to_phases(input logic [2:0] sec, input logic rev);
    phase_sel_t fwd;
    phase_sel_t res;
    fwd.hi = 3'b000;
    fwd.lo = 3'b000;
    case (sec)
      3'd0:    begin fwd.hi = 3'b001; fwd.lo = 3'b010; end
      3'd1:    begin fwd.hi = 3'b001; fwd.lo = 3'b100; end
      3'd2:    begin fwd.hi = 3'b010; fwd.lo = 3'b100; end
      3'd3:    begin fwd.hi = 3'b010; fwd.lo = 3'b001; end
      3'd4:    begin fwd.hi = 3'b100; fwd.lo = 3'b001; end
      3'd5:    begin fwd.hi = 3'b100; fwd.lo = 3'b010; end
      default: begin fwd.hi = 3'b000; fwd.lo = 3'b000; end
    endcase
    res.hi = rev ? fwd.lo : fwd.hi;
    res.lo = rev ? fwd.hi : fwd.lo;
    return res;
  endfunction

endpackage

// File: rtl/bldc_six_step_ctrl_if.sv
// Control/status bundle between the PS-side registers, PWM generator and the commutation controller.
interface bldc_six_step_ctrl_if;

  logic       run;
  logic       dir;
  logic       brake;
  logic       pwm_in;
  logic [2:0] hall;
  logic       ext_fault;
  logic       fault_clr;
  logic [2:0] ph_en;
  logic [2:0] ph_pwm;
  logic [2:0] sector;
  logic       comm_pulse;
  logic [2:0] state;
  logic       fault;
  logic [1:0] fault_code;

  modport master (
    output run, dir, brake, pwm_in, hall, ext_fault, fault_clr,
    input  ph_en, ph_pwm, sector, comm_pulse, state, fault, fault_code
  );

  modport slave (
    input  run, dir, brake, pwm_in, hall, ext_fault, fault_clr,
    output ph_en, ph_pwm, sector, comm_pulse, state, fault, fault_code
  );

endinterface

// File: rtl/hall_filter.sv
// Hall input synchronizer and stability filter; publishes the accepted code,
// its legality and a one-cycle strobe aligned with each code change.
module hall_filter
  import bldc_pkg::*;
#(
  parameter int unsigned HALL_STABLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] hall_raw,
  output logic [2:0] code,
  output logic       valid,
  output logic       chg
);

  localparam int unsigned CNT_W = (HALL_STABLE > 1) ? $clog2(HALL_STABLE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALL_STABLE - 1);

  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             chg_q, chg_d;

  // Count consecutive identical samples; accept once the run length is long enough.
  always_comb begin
    sync1_d = hall_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    if (sync2_q != prev_q) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        code_d = sync2_q;
      end
    end
    valid_d = (hall_to_sector(code_d) != SECTOR_NONE);
    chg_d   = (code_d != code_q);
  end

  // Filter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      prev_q  <= 3'b000;
      cnt_q   <= '0;
      code_q  <= 3'b000;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
    end
  end

  assign code  = code_q;
  assign valid = valid_q;
  assign chg   = chg_q;

endmodule

// File: rtl/bldc_six_step_ctrl.sv
// Six-step commutation controller: Hall-driven sector sequencing, bootstrap
// precharge, brake, stall detection and latched fault handling.
module bldc_six_step_ctrl
  import bldc_pkg::*;
#(
  parameter int unsigned HALL_STABLE      = 16,
  parameter int unsigned PRECHARGE_CYCLES = 1000,
  parameter int unsigned STALL_CYCLES     = 5_000_000
) (
  input logic                 clk,
  input logic                 reset,
  bldc_six_step_ctrl_if.slave bus
);

  localparam int unsigned PC_W = $clog2(PRECHARGE_CYCLES + 1);
  localparam int unsigned SC_W = $clog2(STALL_CYCLES + 1);
  localparam logic [PC_W-1:0] PC_LAST   = PC_W'(PRECHARGE_CYCLES - 1);
  localparam logic [SC_W-1:0] STALL_MAX = SC_W'(STALL_CYCLES);

  logic [2:0]      hf_code;
  logic            hf_valid;
  logic            hf_chg;

  logic            ext_s1_q, ext_s2_q;
  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_cnt_q, pc_cnt_d;
  logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [2:0]      sector_q, sector_d;
  logic            comm_q, comm_d;
  logic [2:0]      ph_en_q, ph_en_d;
  logic [2:0]      ph_pwm_q, ph_pwm_d;
  logic            fault_q, fault_d;
  logic [1:0]      fault_code_q, fault_code_d;

  logic            in_run, in_brake, pc_done, hall_bad, stall_hit, fault_det;
  logic [1:0]      fault_src;
  phase_sel_t      sel;

  hall_filter #(
    .HALL_STABLE (HALL_STABLE)
  ) u_hall_filter (
    .clk      (clk),
    .reset    (reset),
    .hall_raw (bus.hall),
    .code     (hf_code),
    .valid    (hf_valid),
    .chg      (hf_chg)
  );

  // Fault sources, precharge timer and stall timer.
  always_comb begin
    in_run   = (state_q == ST_RUN);
    in_brake = (state_q == ST_BRAKE);
    pc_cnt_d = (state_q == ST_PRECHARGE) ? pc_cnt_q + PC_W'(1) : '0;
    pc_done  = (pc_cnt_q == PC_LAST);
    if (!in_run || hf_chg) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != STALL_MAX) begin
      stall_cnt_d = stall_cnt_q + SC_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    hall_bad  = (in_run || in_brake) && !hf_valid;
    stall_hit = in_run && (stall_cnt_d == STALL_MAX);
    fault_det = ext_s2_q || hall_bad || stall_hit;
    if (ext_s2_q) begin
      fault_src = FC_EXT;
    end else if (hall_bad) begin
      fault_src = FC_HALL;
    end else begin
      fault_src = FC_STALL;
    end
  end

  // Next-state logic; any detected fault overrides the mode requests.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.run && !fault_q) state_d = ST_PRECHARGE;
      end
      ST_PRECHARGE: begin
        if (!bus.run)     state_d = ST_IDLE;
        else if (pc_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.run)       state_d = ST_IDLE;
        else if (bus.brake) state_d = ST_BRAKE;
      end
      ST_BRAKE: begin
        if (!bus.run)        state_d = ST_IDLE;
        else if (!bus.brake) state_d = ST_RUN;
      end
      ST_FAULT: begin
        if (bus.fault_clr && !bus.run && !ext_s2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (fault_det) state_d = ST_FAULT;
  end

  // Output decode from the next state so every output lines up with the state register.
  always_comb begin
    sector_d = hall_to_sector(hf_code);
    sel      = sector_to_phases(sector_d, bus.dir);
    ph_en_d  = 3'b000;
    ph_pwm_d = 3'b000;
    case (state_d)
      ST_PRECHARGE, ST_BRAKE: begin
        ph_en_d = 3'b111;
      end
      ST_RUN: begin
        ph_en_d  = sel.hi | sel.lo;
        ph_pwm_d = sel.hi & {3{bus.pwm_in}};
      end
      default: begin
        ph_en_d  = 3'b000;
        ph_pwm_d = 3'b000;
      end
    endcase
    comm_d  = in_run && (state_d == ST_RUN) && hf_chg && hf_valid;
    fault_d = (state_d == ST_FAULT);
    if (state_d != ST_FAULT) begin
      fault_code_d = FC_NONE;
    end else if (state_q != ST_FAULT) begin
      fault_code_d = fault_src;
    end else begin
      fault_code_d = fault_code_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath, synchronizer and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_s1_q     <= 1'b0;
      ext_s2_q     <= 1'b0;
      pc_cnt_q     <= '0;
      stall_cnt_q  <= '0;
      sector_q     <= SECTOR_NONE;
      comm_q       <= 1'b0;
      ph_en_q      <= 3'b000;
      ph_pwm_q     <= 3'b000;
      fault_q      <= 1'b0;
      fault_code_q <= FC_NONE;
    end else begin
      ext_s1_q     <= bus.ext_fault;
      ext_s2_q     <= ext_s1_q;
      pc_cnt_q     <= pc_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      sector_q     <= sector_d;
      comm_q       <= comm_d;
      ph_en_q      <= ph_en_d;
      ph_pwm_q     <= ph_pwm_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign bus.ph_en      = ph_en_q;
  assign bus.ph_pwm     = ph_pwm_q;
  assign bus.sector     = sector_q;
  assign bus.comm_pulse = comm_q;
  assign bus.state      = state_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;

endmodule

// File: tb/tb_bldc_six_step_ctrl.sv
// Directed bench for the six-step commutation controller.
module tb_bldc_six_step_ctrl;

  localparam int unsigned HS = 4;
  localparam int unsigned PC = 10;
  localparam int unsigned SC = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bldc_six_step_ctrl_if bus ();

  bldc_six_step_ctrl #(
    .HALL_STABLE      (HS),
    .PRECHARGE_CYCLES (PC),
    .STALL_CYCLES     (SC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned vec = 0;
  int unsigned err = 0;
  logic        pwm_prev = 1'b0;

  logic [2:0] hall_tbl [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  logic [2:0] en_tbl   [6] = '{3'b011, 3'b101, 3'b110, 3'b011, 3'b101, 3'b110};
  logic [2:0] hi_fwd   [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
  logic [2:0] lo_fwd   [6] = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};

  // Advance to the next falling edge; pwm_prev is the carrier the last rising edge sampled.
  task automatic tick();
    @(negedge clk);
    pwm_prev   = bus.pwm_in;
    bus.pwm_in = 1'($urandom);
  endtask

  task automatic test_reset();
    bus.run = 1'b0; bus.dir = 1'b0; bus.brake = 1'b0; bus.pwm_in = 1'b0;
    bus.hall = 3'b101; bus.ext_fault = 1'b0; bus.fault_clr = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    vec++; if (bus.ph_en !== 3'b000) begin err++; $display("FAIL rst_ph_en: got %b want 000", bus.ph_en); end
    vec++; if (bus.ph_pwm !== 3'b000) begin err++; $display("FAIL rst_ph_pwm: got %b want 000", bus.ph_pwm); end
    vec++; if (bus.sector !== 3'd7) begin err++; $display("FAIL rst_sector: got %0d want 7", bus.sector); end
    vec++; if (bus.comm_pulse !== 1'b0) begin err++; $display("FAIL rst_comm: got %b want 0", bus.comm_pulse); end
    vec++; if (bus.state !== 3'd0) begin err++; $display("FAIL rst_state: got %0d want 0", bus.state); end
    vec++; if (bus.fault !== 1'b0 || bus.fault_code !== 2'd0) begin
      err++; $display("FAIL rst_fault: got %b/%0d want 0/0", bus.fault, bus.fault_code); end
    reset = 1'b0;
  endtask

  task automatic test_precharge();
    repeat (12) tick();
    vec++; if (bus.state !== 3'd0 || bus.sector !== 3'd0 || bus.ph_en !== 3'b000) begin
      err++; $display("FAIL idle_hall: got state %0d sector %0d en %b want 0 0 000", bus.state, bus.sector, bus.ph_en); end
    bus.run = 1'b1;
    for (int i = 0; i < int'(PC); i++) begin
      tick();
      vec++; if ({bus.state, bus.ph_en, bus.ph_pwm} !== {3'd1, 3'b111, 3'b000}) begin
        err++; $display("FAIL precharge_%0d: got state %0d en %b pwm %b want 1 111 000", i, bus.state, bus.ph_en, bus.ph_pwm); end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vec++; if ({bus.state, bus.ph_en, bus.ph_pwm} !== {3'd2, 3'b011, 2'b00, pwm_prev}) begin
        err++; $display("FAIL run_entry_%0d: got state %0d en %b pwm %b want 2 011 00%b", i, bus.state, bus.ph_en, bus.ph_pwm, pwm_prev); end
    end
  endtask

  task automatic test_sequence(input logic d);
    int pulses;
    int first;
    int idx;
    logic [2:0] hm;
    bus.dir = d;
    tick();
    hm = d ? lo_fwd[0] : hi_fwd[0];
    vec++; if (bus.ph_en !== en_tbl[0] || bus.ph_pwm !== (hm & {3{pwm_prev}})) begin
      err++; $display("FAIL dir_switch_%b: got en %b pwm %b want %b %b", d, bus.ph_en, bus.ph_pwm, en_tbl[0], hm & {3{pwm_prev}}); end
    for (int k = 1; k <= 6; k++) begin
      idx = k % 6;
      hm = d ? lo_fwd[idx] : hi_fwd[idx];
      bus.hall = hall_tbl[idx];
      pulses = 0;
      first = 0;
      for (int t = 1; t <= 20; t++) begin
        tick();
        if (bus.comm_pulse === 1'b1) begin
          pulses++;
          if (first == 0) first = t;
        end
        if (t >= 16) begin
          vec++; if (bus.sector !== 3'(idx) || bus.ph_en !== en_tbl[idx] || bus.ph_pwm !== (hm & {3{pwm_prev}})) begin
            err++; $display("FAIL step_d%b_s%0d: got sector %0d en %b pwm %b want %0d %b %b",
                            d, idx, bus.sector, bus.ph_en, bus.ph_pwm, idx, en_tbl[idx], hm & {3{pwm_prev}}); end
        end
      end
      vec++; if (pulses != 1 || first != int'(HS) + 4) begin
        err++; $display("FAIL comm_d%b_s%0d: got %0d pulses at tick %0d want 1 at %0d", d, idx, pulses, first, HS + 4); end
    end
  endtask

  task automatic test_glitch();
    int pulses;
    pulses = 0;
    bus.hall = 3'b100;
    repeat (3) tick();
    bus.hall = 3'b101;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (bus.comm_pulse === 1'b1) pulses++;
    end
    vec++; if (pulses != 0 || bus.sector !== 3'd0) begin
      err++; $display("FAIL glitch: got %0d pulses sector %0d want 0 pulses sector 0", pulses, bus.sector); end
  endtask

  task automatic test_brake();
    int bad;
    bad = 0;
    bus.dir = 1'b0;
    bus.brake = 1'b1;
    tick();
    vec++; if ({bus.state, bus.ph_en, bus.ph_pwm} !== {3'd3, 3'b111, 3'b000}) begin
      err++; $display("FAIL brake_entry: got state %0d en %b pwm %b want 3 111 000", bus.state, bus.ph_en, bus.ph_pwm); end
    repeat (200) begin
      tick();
      if (bus.state !== 3'd3 || bus.fault !== 1'b0 || bus.ph_en !== 3'b111 || bus.ph_pwm !== 3'b000) bad++;
    end
    vec++; if (bad != 0) begin err++; $display("FAIL brake_hold: got %0d bad cycles want 0", bad); end
    bus.brake = 1'b0;
    tick();
    vec++; if ({bus.state, bus.sector, bus.ph_en, bus.ph_pwm} !== {3'd2, 3'd0, 3'b011, 2'b00, pwm_prev}) begin
      err++; $display("FAIL brake_release: got state %0d sector %0d en %b pwm %b want 2 0 011 00%b",
                      bus.state, bus.sector, bus.ph_en, bus.ph_pwm, pwm_prev); end
  endtask

  task automatic test_stall();
    int n;
    int guard;
    n = 0;
    guard = 0;
    bus.run = 1'b0;
    tick();
    vec++; if (bus.state !== 3'd0 || bus.ph_en !== 3'b000) begin
      err++; $display("FAIL run_drop: got state %0d en %b want 0 000", bus.state, bus.ph_en); end
    bus.run = 1'b1;
    repeat (3) tick();
    bus.run = 1'b0;
    tick();
    vec++; if (bus.state !== 3'd0 || bus.ph_en !== 3'b000) begin
      err++; $display("FAIL precharge_abort: got state %0d en %b want 0 000", bus.state, bus.ph_en); end
    bus.run = 1'b1;
    do begin tick(); guard++; end while (bus.state !== 3'd2 && guard < 50);
    while (bus.state === 3'd2 && n < 400) begin n++; tick(); end
    vec++; if (n != int'(SC)) begin err++; $display("FAIL stall_cycles: got %0d run cycles want %0d", n, SC); end
    vec++; if ({bus.fault, bus.fault_code, bus.state, bus.ph_en, bus.ph_pwm} !== {1'b1, 2'd3, 3'd4, 3'b000, 3'b000}) begin
      err++; $display("FAIL stall_fault: got fault %b code %0d state %0d en %b pwm %b want 1 3 4 000 000",
                      bus.fault, bus.fault_code, bus.state, bus.ph_en, bus.ph_pwm); end
    bus.run = 1'b0;
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    vec++; if ({bus.state, bus.fault, bus.fault_code} !== {3'd0, 1'b0, 2'd0}) begin
      err++; $display("FAIL stall_clear: got state %0d fault %b code %0d want 0 0 0", bus.state, bus.fault, bus.fault_code); end
  endtask

  task automatic test_invalid_hall();
    int guard;
    int t;
    guard = 0;
    t = 0;
    bus.run = 1'b1;
    do begin tick(); guard++; end while (bus.state !== 3'd2 && guard < 50);
    vec++; if (bus.state !== 3'd2) begin err++; $display("FAIL inv_reach_run: got state %0d want 2", bus.state); end
    bus.hall = 3'b111;
    do begin tick(); t++; end while (bus.fault !== 1'b1 && t < 30);
    vec++; if (t != int'(HS) + 4) begin err++; $display("FAIL inv_latency: got %0d want %0d", t, HS + 4); end
    vec++; if ({bus.fault_code, bus.state, bus.ph_en, bus.sector} !== {2'd2, 3'd4, 3'b000, 3'd7}) begin
      err++; $display("FAIL inv_fault: got code %0d state %0d en %b sector %0d want 2 4 000 7",
                      bus.fault_code, bus.state, bus.ph_en, bus.sector); end
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    tick();
    vec++; if ({bus.fault, bus.fault_code, bus.state} !== {1'b1, 2'd2, 3'd4}) begin
      err++; $display("FAIL inv_clr_while_run: got fault %b code %0d state %0d want 1 2 4", bus.fault, bus.fault_code, bus.state); end
    bus.run = 1'b0;
    tick();
    vec++; if (bus.state !== 3'd4) begin err++; $display("FAIL inv_hold: got state %0d want 4", bus.state); end
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    vec++; if ({bus.state, bus.fault, bus.fault_code} !== {3'd0, 1'b0, 2'd0}) begin
      err++; $display("FAIL inv_clear: got state %0d fault %b code %0d want 0 0 0", bus.state, bus.fault, bus.fault_code); end
    bus.hall = 3'b101;
    repeat (12) tick();
  endtask

  task automatic test_ext_priority();
    int guard;
    int t;
    guard = 0;
    t = 0;
    bus.run = 1'b1;
    do begin tick(); guard++; end while (bus.state !== 3'd2 && guard < 50);
    vec++; if (bus.state !== 3'd2) begin err++; $display("FAIL ext_reach_run: got state %0d want 2", bus.state); end
    bus.hall = 3'b111;
    repeat (5) begin tick(); t++; end
    bus.ext_fault = 1'b1;
    do begin tick(); t++; end while (bus.fault !== 1'b1 && t < 30);
    vec++; if (t != int'(HS) + 4) begin err++; $display("FAIL ext_latency: got %0d want %0d", t, HS + 4); end
    vec++; if ({bus.fault_code, bus.state, bus.ph_en} !== {2'd1, 3'd4, 3'b000}) begin
      err++; $display("FAIL ext_priority: got code %0d state %0d en %b want 1 4 000", bus.fault_code, bus.state, bus.ph_en); end
    bus.run = 1'b0;
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    vec++; if ({bus.fault, bus.fault_code, bus.state} !== {1'b1, 2'd1, 3'd4}) begin
      err++; $display("FAIL ext_clr_blocked: got fault %b code %0d state %0d want 1 1 4", bus.fault, bus.fault_code, bus.state); end
    bus.ext_fault = 1'b0;
    bus.hall = 3'b101;
    repeat (3) tick();
    bus.fault_clr = 1'b1;
    tick();
    bus.fault_clr = 1'b0;
    vec++; if ({bus.state, bus.fault, bus.fault_code} !== {3'd0, 1'b0, 2'd0}) begin
      err++; $display("FAIL ext_clear: got state %0d fault %b code %0d want 0 0 0", bus.state, bus.fault, bus.fault_code); end
  endtask

  initial begin
    test_reset();
    test_precharge();
    test_sequence(1'b0);
    test_sequence(1'b1);
    test_glitch();
    test_brake();
    test_stall();
    test_invalid_hall();
    test_ext_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
